// File: rtl/led_blink_sequencer.sv
// Command-driven LED blink sequencer: N on/off cycles timed by an internal prescaler tick.
// Optional abort input enabled by defining LED_BLINK_SEQ_ABORT_EN.
module led_blink_sequencer #(
   parameter int TICK_DIV = 50000,
   parameter int TW       = 16,
   parameter int CW       = 8
) (
   input  logic          clk,
   input  logic          rst_n_async,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [CW-1:0] cmd_count,
   input  logic [TW-1:0] cmd_on_ticks,
   input  logic [TW-1:0] cmd_off_ticks,
`ifdef LED_BLINK_SEQ_ABORT_EN
   input  logic          abort,
`endif
   output logic          busy,
   output logic          done,
   output logic          led
);

   localparam int PW = $clog2(TICK_DIV);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ON   = 2'd1;
   localparam logic [1:0] S_OFF  = 2'd2;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic          done_nxt;
   logic [PW-1:0] presc;
   logic [TW-1:0] phase;
   logic [TW-1:0] on_len;
   logic [TW-1:0] off_len;
   logic [CW-1:0] remaining;
   logic          accept;
   logic          tick;
   logic          on_last;
   logic          off_last;
   logic          phase_end;

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state == S_ON) || (state == S_OFF);
   assign accept    = cmd_valid && cmd_ready;
   assign tick      = (presc == PW'(TICK_DIV - 1));

   // A zero-length phase behaves as a single tick.
   assign on_last  = (on_len == '0) || (phase == on_len - TW'(1));
   assign off_last = (off_len == '0) || (phase == off_len - TW'(1));

   always_comb begin
      phase_end = 1'b0;
      if (state == S_ON)
         phase_end = tick && on_last;
      else if (state == S_OFF)
         phase_end = tick && off_last;
   end

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_count == '0)
                  done_nxt = 1'b1;
               else
                  state_nxt = S_ON;
            end
         end
         S_ON: begin
            if (phase_end)
               state_nxt = S_OFF;
         end
         S_OFF: begin
            if (phase_end) begin
               if (remaining == CW'(1)) begin
                  state_nxt = S_IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = S_ON;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
`ifdef LED_BLINK_SEQ_ABORT_EN
      if (abort && (state != S_IDLE)) begin
         state_nxt = S_IDLE;
         done_nxt  = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n_async) begin
      if (!rst_n_async) begin
         state     <= S_IDLE;
         done      <= 1'b0;
         led       <= 1'b0;
         presc     <= '0;
         phase     <= '0;
         on_len    <= '0;
         off_len   <= '0;
         remaining <= '0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
         led   <= (state_nxt == S_ON);
         if (accept) begin
            // Prescaler restarts so every phase is phase-locked to the accept edge.
            presc     <= '0;
            phase     <= '0;
            on_len    <= cmd_on_ticks;
            off_len   <= cmd_off_ticks;
            remaining <= cmd_count;
         end else if (state != S_IDLE) begin
            presc <= tick ? '0 : presc + PW'(1);
            if (phase_end)
               phase <= '0;
            else if (tick)
               phase <= phase + TW'(1);
            if ((state == S_OFF) && phase_end)
               remaining <= remaining - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed bench for led_blink_sequencer with TICK_DIV=4.
// Abort scenario runs only when LED_BLINK_SEQ_ABORT_EN is defined.
module tb_led_blink_sequencer;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst_n_async;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_count;
   logic [15:0] cmd_on_ticks;
   logic [15:0] cmd_off_ticks;
   logic       busy;
   logic       done;
   logic       led;
`ifdef LED_BLINK_SEQ_ABORT_EN
   logic       abort;
`endif

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   led_blink_sequencer #(
      .TICK_DIV(TD),
      .TW(16),
      .CW(8)
   ) dut (
      .clk(clk),
      .rst_n_async(rst_n_async),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_count(cmd_count),
      .cmd_on_ticks(cmd_on_ticks),
      .cmd_off_ticks(cmd_off_ticks),
`ifdef LED_BLINK_SEQ_ABORT_EN
      .abort(abort),
`endif
      .busy(busy),
      .done(done),
      .led(led)
   );

   typedef struct {
      int cnt;
      int on;
      int off;
      int on_cyc;
      int off_cyc;
      int busy_cyc;
      int done_at;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int c, input int on, input int off);
      cmd_count     = 8'(c);
      cmd_on_ticks  = 16'(on);
      cmd_off_ticks = 16'(off);
      cmd_valid     = 1'b1;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int per;
      bit exp_led;
      bit exp_busy;
      chk($sformatf("v%0d ready_before", idx), int'(cmd_ready), 1);
      issue(v.cnt, v.on, v.off);
      step();
      cmd_valid = 1'b0;
      per = v.on_cyc + v.off_cyc;
      for (int k = 1; k <= v.done_at + 1; k++) begin
         exp_busy = (k <= v.busy_cyc);
         exp_led  = 1'b0;
         if (exp_busy)
            exp_led = (((k - 1) % per) < v.on_cyc);
         chk($sformatf("v%0d c%0d led", idx, k), int'(led), int'(exp_led));
         chk($sformatf("v%0d c%0d busy", idx, k), int'(busy), int'(exp_busy));
         chk($sformatf("v%0d c%0d ready", idx, k), int'(cmd_ready), int'(!exp_busy));
         chk($sformatf("v%0d c%0d done", idx, k), int'(done), int'(k == v.done_at));
         step();
      end
   endtask

   initial begin
      vecs[0] = '{cnt: 2, on: 3, off: 2, on_cyc: 12, off_cyc: 8, busy_cyc: 40, done_at: 41};
      vecs[1] = '{cnt: 0, on: 5, off: 5, on_cyc: 20, off_cyc: 20, busy_cyc: 0, done_at: 1};
      vecs[2] = '{cnt: 1, on: 0, off: 0, on_cyc: 4, off_cyc: 4, busy_cyc: 8, done_at: 9};
      vecs[3] = '{cnt: 3, on: 1, off: 2, on_cyc: 4, off_cyc: 8, busy_cyc: 36, done_at: 37};
      vecs[4] = '{cnt: 1, on: 2, off: 0, on_cyc: 8, off_cyc: 4, busy_cyc: 12, done_at: 13};

      rst_n_async   = 1'b0;
      cmd_valid     = 1'b0;
      cmd_count     = '0;
      cmd_on_ticks  = '0;
      cmd_off_ticks = '0;
`ifdef LED_BLINK_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      #1;
      chk("rst led", int'(led), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst done", int'(done), 0);
      chk("rst ready", int'(cmd_ready), 1);
      step();
      step();
      rst_n_async = 1'b1;
      step();

      for (int i = 0; i < 5; i++)
         run_vec(i, vecs[i]);

      // Reset in the middle of an ON phase
      issue(2, 3, 2);
      step();
      cmd_valid = 1'b0;
      step();
      step();
      chk("midrst led_before", int'(led), 1);
      rst_n_async = 1'b0;
      #2;
      chk("midrst led", int'(led), 0);
      chk("midrst busy", int'(busy), 0);
      chk("midrst ready", int'(cmd_ready), 1);
      step();
      rst_n_async = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("postrst c%0d done", k), int'(done), 0);
         chk($sformatf("postrst c%0d busy", k), int'(busy), 0);
         step();
      end

      // cmd_valid held through the sequence: second accept on the done cycle
      issue(1, 1, 1);
      step();
      for (int k = 1; k <= 8; k++) begin
         chk($sformatf("b2b c%0d led", k), int'(led), int'(k <= 4));
         chk($sformatf("b2b c%0d ready", k), int'(cmd_ready), 0);
         step();
      end
      chk("b2b c9 done", int'(done), 1);
      chk("b2b c9 ready", int'(cmd_ready), 1);
      chk("b2b c9 led", int'(led), 0);
      step();
      cmd_valid = 1'b0;
      chk("b2b c10 led", int'(led), 1);
      chk("b2b c10 busy", int'(busy), 1);
      chk("b2b c10 done", int'(done), 0);
      for (int k = 11; k <= 17; k++)
         step();
      chk("b2b c17 busy", int'(busy), 1);
      step();
      chk("b2b c18 done", int'(done), 1);
      chk("b2b c18 busy", int'(busy), 0);
      step();

`ifdef LED_BLINK_SEQ_ABORT_EN
      // Abort in IDLE together with a command: accept wins
      issue(3, 2, 2);
      abort = 1'b1;
      step();
      cmd_valid = 1'b0;
      abort = 1'b0;
      chk("abt accept busy", int'(busy), 1);
      chk("abt accept led", int'(led), 1);
      for (int k = 2; k <= 28; k++)
         step();
      chk("abt c28 busy", int'(busy), 1);
      chk("abt c28 led", int'(led), 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abt c29 busy", int'(busy), 0);
      chk("abt c29 led", int'(led), 0);
      chk("abt c29 ready", int'(cmd_ready), 1);
      for (int k = 0; k < 20; k++) begin
         chk($sformatf("abt post%0d done", k), int'(done), 0);
         chk($sformatf("abt post%0d led", k), int'(led), 0);
         step();
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
